cu_vertex_cache_read_arbiter: RTL and testbench

//  Shares the vertex-cache read command path between NUM_READ_REQUESTS requesters (graph/vertex CU job,

---
 rtl/cu_vertex_cache_read_arbiter.sv | 153 +++++++++++++++
 tb/tb_cu_vertex_cache_read_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_vertex_cache_read_arbiter.sv
// Round-robin arbiter that shares the vertex-cache read command path between
// several requesters. It holds one registered command toward the cache, bounds
// in-flight reads with an outstanding counter and routes completions back.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | disabled and fully drained; no commands held or outstanding
// ACTIVE | enabled; grants new requests when slot and credit allow
// DRAIN  | enable dropped; no new grants, waiting for held/outstanding reads
module cu_vertex_cache_read_arbiter #(
    parameter int NUM_READ_REQUESTS = 4,
    parameter int CMD_W             = 64,
    parameter int MAX_OUTSTANDING   = 16,
    localparam int SRC_W            = $clog2(NUM_READ_REQUESTS),
    localparam int CNT_W            = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                               clock,
    input  logic                               rst_in,
    input  logic                               enabled_in,
    input  logic [NUM_READ_REQUESTS-1:0]       req_valid_in,
    input  logic [NUM_READ_REQUESTS*CMD_W-1:0] req_payload_in,
    output logic [NUM_READ_REQUESTS-1:0]       req_ready_out,
    output logic                               cmd_valid_out,
    output logic [CMD_W-1:0]                   cmd_payload_out,
    output logic [SRC_W-1:0]                   cmd_src_out,
    input  logic                               cmd_ready_in,
    input  logic                               rsp_valid_in,
    input  logic [SRC_W-1:0]                   rsp_src_in,
    output logic [NUM_READ_REQUESTS-1:0]       rsp_valid_out,
    output logic [CNT_W-1:0]                   outstanding_out,
    output logic                               idle_out,
    output logic                               error_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] winner;
    logic [SRC_W-1:0] winner_next_ptr;
    logic             found;
    logic             slot_free;
    logic             credit_ok;
    logic             grant_en;
    logic             grant;
    logic             issue;

    assign issue     = cmd_valid_out & cmd_ready_in;
    assign slot_free = ~cmd_valid_out | cmd_ready_in;
    // The held command has already consumed a credit even though it is not yet issued.
    assign credit_ok = ({1'b0, outstanding_out} + (CNT_W+1)'(cmd_valid_out))
                       < (CNT_W+1)'(MAX_OUTSTANDING);
    assign grant_en  = (state == ACTIVE) & slot_free & credit_ok;
    assign grant     = grant_en & found;
    assign idle_out  = (state == IDLE);

    assign winner_next_ptr = (winner == SRC_W'(NUM_READ_REQUESTS - 1)) ? '0
                                                                      : winner + SRC_W'(1);

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        int scan_idx;
        scan_idx = 0;
        found    = 1'b0;
        winner   = '0;
        for (int k = 0; k < NUM_READ_REQUESTS; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_READ_REQUESTS;
            if (!found && req_valid_in[scan_idx]) begin
                found  = 1'b1;
                winner = SRC_W'(scan_idx);
            end
        end
    end

    // One-hot grant to the winner only when a grant is actually possible.
    always_comb begin
        req_ready_out = '0;
        if (grant) begin
            req_ready_out = NUM_READ_REQUESTS'(1) << winner;
        end
    end

    // Next-state logic; re-enabling during drain takes priority over going idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enabled_in) state_next = ACTIVE;
            ACTIVE:  if (!enabled_in) state_next = DRAIN;
            DRAIN: begin
                if (enabled_in) begin
                    state_next = ACTIVE;
                end else if (outstanding_out == '0 && !cmd_valid_out) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, command slot and round-robin pointer.
    always_ff @(posedge clock) begin
        if (rst_in) begin
            state           <= IDLE;
            cmd_valid_out   <= 1'b0;
            cmd_payload_out <= '0;
            cmd_src_out     <= '0;
            rr_ptr          <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                cmd_valid_out   <= 1'b1;
                cmd_payload_out <= req_payload_in[winner*CMD_W +: CMD_W];
                cmd_src_out     <= winner;
                rr_ptr          <= winner_next_ptr;
            end else if (issue) begin
                cmd_valid_out <= 1'b0;
            end
        end
    end

    // Outstanding counter with sticky underflow error; it never wraps.
    always_ff @(posedge clock) begin
        if (rst_in) begin
            outstanding_out <= '0;
            error_out       <= 1'b0;
        end else if (issue && !rsp_valid_in) begin
            outstanding_out <= outstanding_out + CNT_W'(1);
        end else if (!issue && rsp_valid_in) begin
            if (outstanding_out == '0) begin
                error_out <= 1'b1;
            end else begin
                outstanding_out <= outstanding_out - CNT_W'(1);
            end
        end
    end

    // Completion routing; a tag beyond the requester range shifts out to all-zero.
    always_ff @(posedge clock) begin
        if (rst_in) begin
            rsp_valid_out <= '0;
        end else if (rsp_valid_in) begin
            rsp_valid_out <= NUM_READ_REQUESTS'(1) << rsp_src_in;
        end else begin
            rsp_valid_out <= '0;
        end
    end

endmodule

// File: tb/tb_cu_vertex_cache_read_arbiter.sv
// Scoreboard bench for cu_vertex_cache_read_arbiter: a behavioural model
// predicts each cycle's outputs and the order of issued commands; a monitor
// compares the DUT against those predictions.
module tb_cu_vertex_cache_read_arbiter;

    localparam int N     = 4;
    localparam int CMD_W = 64;
    localparam int MAX   = 16;
    localparam int M_IDLE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_DRAIN  = 2;

    logic             clock;
    logic             rst_in;
    logic             enabled_in;
    logic [N-1:0]     req_valid_in;
    logic [N*CMD_W-1:0] req_payload_in;
    logic [N-1:0]     req_ready_out;
    logic             cmd_valid_out;
    logic [CMD_W-1:0] cmd_payload_out;
    logic [1:0]       cmd_src_out;
    logic             cmd_ready_in;
    logic             rsp_valid_in;
    logic [1:0]       rsp_src_in;
    logic [N-1:0]     rsp_valid_out;
    logic [4:0]       outstanding_out;
    logic             idle_out;
    logic             error_out;

    cu_vertex_cache_read_arbiter #(
        .NUM_READ_REQUESTS(N),
        .CMD_W(CMD_W),
        .MAX_OUTSTANDING(MAX)
    ) dut (
        .clock(clock),
        .rst_in(rst_in),
        .enabled_in(enabled_in),
        .req_valid_in(req_valid_in),
        .req_payload_in(req_payload_in),
        .req_ready_out(req_ready_out),
        .cmd_valid_out(cmd_valid_out),
        .cmd_payload_out(cmd_payload_out),
        .cmd_src_out(cmd_src_out),
        .cmd_ready_in(cmd_ready_in),
        .rsp_valid_in(rsp_valid_in),
        .rsp_src_in(rsp_src_in),
        .rsp_valid_out(rsp_valid_out),
        .outstanding_out(outstanding_out),
        .idle_out(idle_out),
        .error_out(error_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        bit          skip;
        logic [3:0]  ready;
        bit          cv;
        logic [1:0]  src;
        logic [63:0] pay;
        int          outs;
        logic [3:0]  rsp;
        bit          idle;
        bit          err;
    } exp_t;

    typedef struct {
        logic [1:0]  src;
        logic [63:0] pay;
    } cmd_t;

    exp_t exp_q[$];
    cmd_t cmd_q[$];

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    bit          m_known = 1'b0;
    int          m_state = M_IDLE;
    bit          m_cv    = 1'b0;
    int          m_src   = 0;
    logic [63:0] m_pay   = '0;
    int          m_out   = 0;
    int          m_rr    = 0;
    bit          m_err   = 1'b0;
    logic [3:0]  m_rsp   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic bound_fail(input string name);
        n_total++;
        $display("FAIL %s: cycle budget expired at %0t", name, $time);
    endtask

    // Drive one cycle of stimulus and advance the reference model.
    task automatic tick(input bit rst, input bit en, input logic [3:0] rv,
                        input bit cr, input bit rspv, input int rsrc);
        logic [63:0] pays[N];
        exp_t        e;
        int          win;
        bit          can;
        bit          iss;
        @(negedge clock);
        for (int i = 0; i < N; i++) pays[i] = {$urandom, $urandom};
        rst_in       = rst;
        enabled_in   = en;
        req_valid_in = rv;
        cmd_ready_in = rst ? 1'b0 : cr;
        rsp_valid_in = rst ? 1'b0 : rspv;
        rsp_src_in   = 2'(rsrc);
        for (int i = 0; i < N; i++) req_payload_in[i*CMD_W +: CMD_W] = pays[i];

        win = -1;
        can = (m_state == M_ACTIVE) && (!m_cv || cmd_ready_in) && (m_out + int'(m_cv) < MAX);
        if (can) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (win < 0 && rv[idx]) win = idx;
            end
        end
        e.skip  = !m_known;
        e.ready = (win >= 0) ? 4'(1 << win) : 4'b0;
        e.cv    = m_cv;
        e.src   = 2'(m_src);
        e.pay   = m_pay;
        e.outs  = m_out;
        e.rsp   = m_rsp;
        e.idle  = (m_state == M_IDLE);
        e.err   = m_err;
        exp_q.push_back(e);

        if (rst) begin
            m_known = 1'b1;
            m_state = M_IDLE;
            m_cv    = 1'b0;
            m_src   = 0;
            m_pay   = '0;
            m_out   = 0;
            m_rr    = 0;
            m_err   = 1'b0;
            m_rsp   = '0;
            cmd_q.delete();
        end else begin
            iss = m_cv && cmd_ready_in;
            case (m_state)
                M_IDLE:   if (en) m_state = M_ACTIVE;
                M_ACTIVE: if (!en) m_state = M_DRAIN;
                default: begin
                    if (en) m_state = M_ACTIVE;
                    else if (m_out == 0 && !m_cv) m_state = M_IDLE;
                end
            endcase
            if (iss && !rspv) m_out++;
            else if (rspv && !iss) begin
                if (m_out == 0) m_err = 1'b1;
                else m_out--;
            end
            m_rsp = (rspv && rsrc < N) ? 4'(1 << rsrc) : 4'b0;
            if (win >= 0) begin
                m_cv  = 1'b1;
                m_src = win;
                m_pay = pays[win];
                m_rr  = (win + 1) % N;
                cmd_q.push_back('{2'(win), pays[win]});
            end else if (iss) begin
                m_cv = 1'b0;
            end
        end
    endtask

    // Monitor: compares visible outputs each cycle and pops issued commands.
    initial begin
        exp_t e;
        cmd_t c;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!e.skip) begin
                    chk("req_ready", 64'(req_ready_out), 64'(e.ready));
                    chk("cmd_valid", 64'(cmd_valid_out), 64'(e.cv));
                    if (e.cv) begin
                        chk("cmd_src_held", 64'(cmd_src_out), 64'(e.src));
                        chk("cmd_payload_held", cmd_payload_out, e.pay);
                    end
                    chk("outstanding", 64'(outstanding_out), 64'(e.outs));
                    chk("rsp_valid_out", 64'(rsp_valid_out), 64'(e.rsp));
                    chk("idle", 64'(idle_out), 64'(e.idle));
                    chk("error", 64'(error_out), 64'(e.err));
                    if (cmd_valid_out && cmd_ready_in) begin
                        if (cmd_q.size() == 0) begin
                            n_total++;
                            $display("FAIL issue_order: got src %0d with no granted command pending at %0t",
                                     cmd_src_out, $time);
                        end else begin
                            c = cmd_q.pop_front();
                            chk("issue_src", 64'(cmd_src_out), 64'(c.src));
                            chk("issue_payload", cmd_payload_out, c.pay);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        rst_in         = 1'b1;
        enabled_in     = 1'b0;
        req_valid_in   = 4'hF;
        req_payload_in = '0;
        cmd_ready_in   = 1'b0;
        rsp_valid_in   = 1'b0;
        rsp_src_in     = '0;

        // Reset with all requesters asserting, then enable
        tick(1, 0, 4'hF, 0, 0, 0);
        tick(1, 0, 4'hF, 0, 0, 0);
        tick(0, 0, 4'hF, 1, 0, 0);

        // Fairness with everybody requesting
        repeat (10) tick(0, 1, 4'hF, 1, 0, 0);

        // Backpressure on a held command, then release
        repeat (5) tick(0, 1, 4'hF, 0, 0, 0);
        repeat (3) tick(0, 1, 4'hF, 1, 0, 0);

        // Fill to the outstanding limit
        guard = 0;
        while (m_out < MAX && guard < 40) begin
            tick(0, 1, 4'hF, 1, 0, 0);
            guard++;
        end
        if (m_out < MAX) bound_fail("fill_to_max");
        repeat (3) tick(0, 1, 4'hF, 1, 0, 0);
        tick(0, 1, 4'hF, 1, 1, 1);
        repeat (3) tick(0, 1, 4'hF, 1, 0, 0);

        // Bring outstanding down to 7 with nothing held
        guard = 0;
        while ((m_out != 7 || m_cv) && guard < 40) begin
            tick(0, 1, 4'h0, 1, (m_out > 7) ? 1'b1 : 1'b0, guard % N);
            guard++;
        end
        if (m_out != 7 || m_cv) bound_fail("settle_at_7");
        tick(0, 1, 4'b0100, 1, 0, 0);
        tick(0, 1, 4'h0, 1, 1, 3);
        tick(0, 1, 4'h0, 1, 0, 0);

        // Drain to zero, then a stray completion
        guard = 0;
        while (m_out > 0 && guard < 40) begin
            tick(0, 1, 4'h0, 1, 1, $urandom_range(0, N - 1));
            guard++;
        end
        if (m_out > 0) bound_fail("drain_to_zero");
        tick(0, 1, 4'h0, 1, 1, 2);
        repeat (2) tick(0, 1, 4'h0, 1, 0, 0);

        // Drop enable with a held command and three outstanding
        tick(1, 0, 4'h0, 0, 0, 0);
        tick(0, 1, 4'h0, 1, 0, 0);
        repeat (4) tick(0, 1, 4'hF, 1, 0, 0);
        tick(0, 0, 4'hF, 0, 0, 0);
        tick(0, 0, 4'hF, 1, 0, 0);
        repeat (2) tick(0, 0, 4'hF, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 4'hF, 1, 1, i);
        repeat (3) tick(0, 0, 4'hF, 1, 0, 0);

        // Reset in the middle of a drain
        tick(0, 1, 4'h0, 1, 0, 0);
        repeat (3) tick(0, 1, 4'hF, 1, 0, 0);
        tick(0, 0, 4'hF, 0, 0, 0);
        tick(1, 0, 4'hF, 0, 0, 0);
        repeat (2) tick(0, 0, 4'hF, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit rspv;
            rspv = (m_out > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            tick($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                 rspv, $urandom_range(0, N - 1));
        end
        repeat (3) tick(0, 1, 4'h0, 1, 0, 0);

        @(negedge clock);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
